usb_in_ep_scheduler: RTL and testbench

- Round-robin scheduler that shares the single USB device packet transmitter among NUM_EP IN endpoints.
- Arbitrates between endpoint requests, launches one packet per grant, and steers transmitter byte pulls to the granted endpoint.
- Counts bytes, detects length mismatch and a stalled transmitter, then reports completion per endpoint.
- Sits between the endpoint buffers and the usb_device transmit path; gated by the device enable usb_en.

---
 rtl/usb_in_ep_scheduler.sv | 174 +++++++++++++++++
 tb/tb_usb_in_ep_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_ep_scheduler.sv
// rtl/usb_in_ep_scheduler.sv - round-robin scheduler sharing the USB IN transmitter among endpoints
module usb_in_ep_scheduler #(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = 64,
  parameter int LW      = $clog2(MAX_PKT + 1),
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 usb_en,
  input  logic [NUM_EP-1:0]    ep_req,
  input  logic [NUM_EP*LW-1:0] ep_len,
  input  logic [NUM_EP*8-1:0]  ep_data,
  output logic [NUM_EP-1:0]    ep_gnt,
  output logic [NUM_EP-1:0]    ep_rd,
  output logic [NUM_EP-1:0]    ep_done,
  output logic                 ep_err,
  output logic                 tx_start,
  output logic [2:0]           tx_ep,
  output logic [LW-1:0]        tx_len,
  input  logic                 tx_rd,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 tx_abort,
  output logic                 busy
);

  localparam int            WW      = $clog2(TIMEOUT + 1);
  // The watchdog fires on the edge where it would reach TIMEOUT.
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [LW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_DONE} state_t;

  state_t              state_q;
  logic [NUM_EP-1:0]   gnt_q;
  logic [NUM_EP-1:0]   done_q;
  logic [2:0]          last_ep_q;
  logic [2:0]          tx_ep_q;
  logic [LW-1:0]       tx_len_q;
  logic [LW-1:0]       cnt_q;
  logic [WW-1:0]       wd_q;
  logic                ovr_q;
  logic                err_q;
  logic                start_q;
  logic                abort_q;

  logic [7:0]          req_pad;
  logic [3:0]          cand;
  logic                pick_found;
  logic [2:0]          pick_idx;
  logic [NUM_EP-1:0]   pick_oh;
  logic [LW-1:0]       pick_len;
  logic                in_xfer;
  logic                fwd;
  logic                ovr_d;
  logic [LW-1:0]       cnt_d;

  // Round-robin pick: first requester scanning upward from the endpoint after last_ep.
  always_comb begin
    req_pad    = 8'(ep_req);
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_EP; k++) begin
      cand = {1'b0, last_ep_q} + 4'(k);
      if (cand >= 4'(NUM_EP)) cand = cand - 4'(NUM_EP);
      if (!pick_found && req_pad[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // Byte accounting: forward pulls only while the packet still has bytes left.
  always_comb begin
    in_xfer = (state_q == S_XFER);
    fwd     = in_xfer && tx_rd && (cnt_q < tx_len_q);
    ovr_d   = ovr_q | (in_xfer && tx_rd && (cnt_q >= tx_len_q));
    cnt_d   = (in_xfer && tx_rd && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end

  // Per-endpoint slice steering for the pick (length) and the grant (data, pops).
  always_comb begin
    pick_oh  = '0;
    pick_len = '0;
    tx_data  = '0;
    ep_rd    = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_oh[i] = 1'b1;
        pick_len   = ep_len[i*LW +: LW];
      end
      if (tx_ep_q == 3'(i)) begin
        tx_data  = ep_data[i*8 +: 8];
        ep_rd[i] = fwd;
      end
    end
  end

  // Packet FSM with registered strobes; ep_done/ep_err/tx_abort are visible during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      last_ep_q <= 3'(NUM_EP - 1);
      tx_ep_q   <= '0;
      tx_len_q  <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      ovr_q     <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (usb_en && pick_found) begin
            gnt_q    <= pick_oh;
            tx_ep_q  <= pick_idx;
            tx_len_q <= pick_len;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          start_q <= 1'b1;
          wd_q    <= '0;
          state_q <= S_XFER;
        end
        S_XFER: begin
          cnt_q <= cnt_d;
          ovr_q <= ovr_d;
          if (tx_done) begin
            done_q  <= gnt_q;
            err_q   <= ovr_d | (cnt_d != tx_len_q);
            state_q <= S_DONE;
          end else if (tx_rd) begin
            wd_q <= '0;
          end else if (wd_q == WD_LAST) begin
            abort_q <= 1'b1;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DONE: begin
          last_ep_q <= tx_ep_q;
          gnt_q     <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ep_gnt   = gnt_q;
  assign ep_done  = done_q;
  assign ep_err   = err_q;
  assign tx_start = start_q;
  assign tx_abort = abort_q;
  assign tx_ep    = tx_ep_q;
  assign tx_len   = tx_len_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_in_ep_scheduler.sv
// tb/tb_usb_in_ep_scheduler.sv - scoreboard bench for usb_in_ep_scheduler
module tb_usb_in_ep_scheduler;

  localparam int NUM_EP  = 4;
  localparam int LW      = 7;
  localparam int K_START = 0;
  localparam int K_RD    = 1;
  localparam int K_ABORT = 2;
  localparam int K_DONE  = 3;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          usb_en  = 1'b0;
  logic          tx_rd   = 1'b0;
  logic          tx_done = 1'b0;
  logic [3:0]    ep_req  = '0;
  logic [27:0]   ep_len  = '0;
  logic [31:0]   ep_data = '0;
  logic [3:0]    ep_gnt;
  logic [3:0]    ep_rd;
  logic [3:0]    ep_done;
  logic          ep_err;
  logic          tx_start;
  logic [2:0]    tx_ep;
  logic [LW-1:0] tx_len;
  logic [7:0]    tx_data;
  logic          tx_abort;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int kind;
    int vec;
    int data;
    int at;
  } exp_t;

  exp_t sb[$];

  usb_in_ep_scheduler #(
    .NUM_EP (NUM_EP),
    .MAX_PKT(64),
    .LW     (LW),
    .TIMEOUT(255)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .usb_en  (usb_en),
    .ep_req  (ep_req),
    .ep_len  (ep_len),
    .ep_data (ep_data),
    .ep_gnt  (ep_gnt),
    .ep_rd   (ep_rd),
    .ep_done (ep_done),
    .ep_err  (ep_err),
    .tx_start(tx_start),
    .tx_ep   (tx_ep),
    .tx_len  (tx_len),
    .tx_rd   (tx_rd),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .tx_abort(tx_abort),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int vec, input int data, input int at);
    exp_t e;
    e.kind = kind;
    e.vec  = vec;
    e.data = data;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic expect_evt(input int kind, input logic [31:0] vec, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event_kind", kind, 32'hFF);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk($sformatf("event%0d_vec", e.kind), vec, e.vec);
      chk($sformatf("event%0d_data", e.kind), data, e.data);
      if (e.at >= 0) chk($sformatf("event%0d_cycle", e.kind), cyc, e.at);
    end
  endtask

  // Monitor: every DUT strobe must match the head of the scoreboard, in a fixed per-cycle order.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot0", 32'($onehot0(ep_gnt)), 1);
      chk("done_onehot0", 32'($onehot0(ep_done)), 1);
      if (tx_start) expect_evt(K_START, tx_ep, tx_len);
      if (|ep_rd) expect_evt(K_RD, ep_rd, tx_data);
      if (tx_abort) expect_evt(K_ABORT, 0, 0);
      if (|ep_done) expect_evt(K_DONE, ep_done, ep_err);
    end
  end

  task automatic wait_start();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tx_start && n < 40);
    chk("tx_start_seen", tx_start, 1);
  endtask

  task automatic xfer_body(input int ep, input int len, input int nrd, input int err);
    for (int b = 0; b < nrd; b++) begin
      ep_data[ep*8 +: 8] = 8'(160 + 16*ep + b);
      if (b < len) push(K_RD, 1 << ep, 160 + 16*ep + b, -1);
      tx_rd = 1'b1;
      @(posedge clk); #1;
    end
    tx_rd = 1'b0;
    push(K_DONE, 1 << ep, err, -1);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    chk("busy_in_done", busy, 1);
    chk("gnt_held_in_done", ep_gnt, 1 << ep);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("gnt_after_done", ep_gnt, 0);
  endtask

  task automatic do_pkt(input int ep, input int len, input int nrd, input int err,
                        input int at, input bit hold);
    push(K_START, ep, len, at);
    wait_start();
    if (!hold) ep_req = '0;
    xfer_body(ep, len, nrd, err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ep_gnt"}, ep_gnt, 0);
    chk({tag, "_ep_rd"}, ep_rd, 0);
    chk({tag, "_ep_done"}, ep_done, 0);
    chk({tag, "_ep_err"}, ep_err, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_abort"}, tx_abort, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_ep"}, tx_ep, 0);
    chk({tag, "_tx_len"}, tx_len, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all_zero("reset");

    // Single 3-byte packet on endpoint 0 with latency check.
    usb_en = 1'b1;
    ep_len[0 +: 7] = 7'd3;
    ep_req = 4'b0001;
    do_pkt(0, 3, 3, 0, cyc + 2, 1'b0);

    // All endpoints requesting from reset: grants rotate 0,1,2,3,0.
    do_reset();
    ep_len = {4{7'd1}};
    ep_req = 4'b1111;
    for (int i = 0; i < 5; i++) do_pkt(i % 4, 1, 1, 0, (i == 0) ? cyc + 2 : -1, 1'b1);
    ep_req = '0;

    // Overrun: len 2 with 3 pulls; then a clean zero-length packet.
    ep_len[7 +: 7] = 7'd2;
    ep_req = 4'b0010;
    do_pkt(1, 2, 3, 1, cyc + 2, 1'b0);
    ep_len[21 +: 7] = 7'd0;
    ep_req = 4'b1000;
    do_pkt(3, 0, 0, 0, cyc + 2, 1'b0);

    // usb_en gating: no grant while low, packet survives usb_en falling mid-transfer.
    usb_en = 1'b0;
    ep_len[7 +: 7] = 7'd2;
    ep_req = 4'b0010;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("no_grant_disabled_busy", busy, 0);
    chk("no_grant_disabled_gnt", ep_gnt, 0);
    usb_en = 1'b1;
    push(K_START, 1, 2, cyc + 2);
    wait_start();
    usb_en = 1'b0;
    xfer_body(1, 2, 2, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("no_regrant_disabled_busy", busy, 0);
    ep_req = '0;
    usb_en = 1'b1;

    // Watchdog: 255 silent cycles after tx_start give abort plus errored done.
    ep_len[14 +: 7] = 7'd4;
    ep_req = 4'b0100;
    push(K_START, 2, 4, cyc + 2);
    wait_start();
    t0 = cyc;
    ep_req = '0;
    push(K_ABORT, 0, 0, t0 + 255);
    push(K_DONE, 4, 1, t0 + 255);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ep_done == 4'b0000 && n < 400);
    chk("timeout_done", ep_done, 4'b0100);
    chk("timeout_abort", tx_abort, 1);
    chk("timeout_busy_done", busy, 1);
    @(posedge clk); #1;
    chk("timeout_busy_after", busy, 0);
    chk("timeout_abort_after", tx_abort, 0);

    // Reset mid-transfer: last_ep becomes 1, then ep2 is interrupted after one byte.
    ep_len[7 +: 7] = 7'd2;
    ep_req = 4'b0010;
    do_pkt(1, 2, 2, 0, cyc + 2, 1'b0);
    ep_len[14 +: 7] = 7'd4;
    ep_req = 4'b0100;
    push(K_START, 2, 4, cyc + 2);
    wait_start();
    ep_req = '0;
    ep_data[16 +: 8] = 8'h5A;
    push(K_RD, 4, 8'h5A, -1);
    tx_rd = 1'b1;
    @(posedge clk); #1;
    tx_rd = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tx_rd = 1'b1;
    tx_done = 1'b1;
    #1;
    chk_all_zero("midreset");
    tx_rd = 1'b0;
    tx_done = 1'b0;
    rst = 1'b0;
    ep_len[0 +: 7] = 7'd1;
    ep_req = 4'b1111;
    do_pkt(0, 1, 1, 0, cyc + 2, 1'b0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
